spi_ram_arbiter: RTL and testbench

//  Sits between the SPI slave and the single-port RAM. Decodes SPI command words and

---
 rtl/spi_ram_arbiter_pkg.sv | 32 +++
 rtl/spi_ram_arbiter_rr_arb2.sv | 32 +++
 rtl/spi_ram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI/RAM arbiter: command codes, FSM states and requester IDs.
package spi_ram_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [1:0] {
      ST_ARB    = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   typedef enum logic {
      REQ_SPI = 1'b0,
      REQ_LOC = 1'b1
   } req_id_t;

   // Bit positions of each requester in the arbiter request/grant vectors
   localparam int IDX_SPI = 0;
   localparam int IDX_LOC = 1;

   function automatic logic is_ram_cmd(input logic [1:0] cmd);
      return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA);
   endfunction

   function automatic logic is_addr_cmd(input logic [1:0] cmd);
      return (cmd == CMD_WR_ADDR) || (cmd == CMD_RD_ADDR);
   endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   req_id_t last_gnt;

   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_gnt == REQ_LOC) ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= REQ_LOC;
      end else if (advance && (gnt != 2'b00)) begin
         last_gnt <= gnt[IDX_LOC] ? REQ_LOC : REQ_SPI;
      end
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and RAM sequencer sharing one RAM port round-robin with a local requester.
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_W    = 8
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W+1:0]    spi_rx_data,
   input  logic                 spi_rx_valid,
   output logic [DATA_W-1:0]    spi_tx_data,
   output logic                 spi_tx_valid,
   output logic                 spi_ovf,
   input  logic                 loc_req,
   input  logic                 loc_we,
   input  logic [ADDR_SIZE-1:0] loc_addr,
   input  logic [DATA_W-1:0]    loc_wdata,
   output logic                 loc_gnt,
   output logic [DATA_W-1:0]    loc_rdata,
   output logic                 loc_rvalid,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic [DATA_W-1:0]    ram_wdata,
   input  logic [DATA_W-1:0]    ram_rdata
);

   state_t               state;
   req_id_t              op_id;
   logic                 pend_full;
   logic [1:0]           pend_cmd;
   logic [DATA_W-1:0]    pend_data;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;

   logic                 in_arb;
   logic                 addr_cmd;
   logic                 spi_ram_req;
   logic [1:0]           arb_req;
   logic [1:0]           arb_gnt;
   logic                 pend_take;

   // Address-only commands take the ARB cycle themselves and block arbitration for it
   always_comb begin
      in_arb      = (state == ST_ARB);
      addr_cmd    = in_arb && pend_full && is_addr_cmd(pend_cmd);
      spi_ram_req = pend_full && is_ram_cmd(pend_cmd);
      arb_req     = '0;
      if (in_arb && !addr_cmd) begin
         arb_req[IDX_SPI] = spi_ram_req;
         arb_req[IDX_LOC] = loc_req;
      end
      pend_take   = addr_cmd || arb_gnt[IDX_SPI];
   end

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req),
      .advance (in_arb),
      .gnt     (arb_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_full <= 1'b0;
         pend_cmd  <= '0;
         pend_data <= '0;
         spi_ovf   <= 1'b0;
      end else begin
         if (pend_take) begin
            pend_full <= 1'b0;
         end
         if (spi_rx_valid) begin
            if (!pend_full || pend_take) begin
               pend_full <= 1'b1;
               pend_cmd  <= spi_rx_data[DATA_W+1:DATA_W];
               pend_data <= spi_rx_data[DATA_W-1:0];
            end else begin
               spi_ovf <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_ARB;
         op_id        <= REQ_LOC;
         wr_addr      <= '0;
         rd_addr      <= '0;
         spi_tx_data  <= '0;
         spi_tx_valid <= 1'b0;
         loc_gnt      <= 1'b0;
         loc_rdata    <= '0;
         loc_rvalid   <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
      end else begin
         spi_tx_valid <= 1'b0;
         loc_rvalid   <= 1'b0;
         loc_gnt      <= 1'b0;
         ram_en       <= 1'b0;
         ram_we       <= 1'b0;
         case (state)
            ST_ARB: begin
               if (addr_cmd) begin
                  if (pend_cmd == CMD_WR_ADDR) begin
                     wr_addr <= ADDR_SIZE'(pend_data);
                  end else begin
                     rd_addr <= ADDR_SIZE'(pend_data);
                  end
               end else if (arb_gnt[IDX_SPI]) begin
                  state  <= ST_ACCESS;
                  op_id  <= REQ_SPI;
                  ram_en <= 1'b1;
                  if (pend_cmd == CMD_WR_DATA) begin
                     ram_we    <= 1'b1;
                     ram_addr  <= wr_addr;
                     ram_wdata <= pend_data;
                  end else begin
                     ram_addr  <= rd_addr;
                  end
               end else if (arb_gnt[IDX_LOC]) begin
                  state    <= ST_ACCESS;
                  op_id    <= REQ_LOC;
                  ram_en   <= 1'b1;
                  ram_we   <= loc_we;
                  ram_addr <= loc_addr;
                  loc_gnt  <= 1'b1;
                  if (loc_we) begin
                     ram_wdata <= loc_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               state <= ram_we ? ST_ARB : ST_RESP;
            end
            ST_RESP: begin
               state <= ST_ARB;
               if (op_id == REQ_SPI) begin
                  spi_tx_data  <= ram_rdata;
                  spi_tx_valid <= 1'b1;
               end else begin
                  loc_rdata    <= ram_rdata;
                  loc_rvalid   <= 1'b1;
               end
            end
            default: begin
               state <= ST_ARB;
            end
         endcase
      end
   end

   ram_en_spacing: assert property (@(posedge clk) disable iff (rst) ram_en |=> !ram_en);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a synchronous RAM model and an access monitor.
module tb_spi_ram_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW+1:0] spi_rx_data;
   logic          spi_rx_valid;
   logic [DW-1:0] spi_tx_data;
   logic          spi_tx_valid;
   logic          spi_ovf;
   logic          loc_req;
   logic          loc_we;
   logic [AW-1:0] loc_addr;
   logic [DW-1:0] loc_wdata;
   logic          loc_gnt;
   logic [DW-1:0] loc_rdata;
   logic          loc_rvalid;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   spi_ram_arbiter #(.ADDR_SIZE(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .spi_rx_data  (spi_rx_data),
      .spi_rx_valid (spi_rx_valid),
      .spi_tx_data  (spi_tx_data),
      .spi_tx_valid (spi_tx_valid),
      .spi_ovf      (spi_ovf),
      .loc_req      (loc_req),
      .loc_we       (loc_we),
      .loc_addr     (loc_addr),
      .loc_wdata    (loc_wdata),
      .loc_gnt      (loc_gnt),
      .loc_rdata    (loc_rdata),
      .loc_rvalid   (loc_rvalid),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data appears the cycle after ram_en
   logic [DW-1:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ram_rdata = 8'h00;
   end
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   // Access log: who drove each RAM access, plus spacing and tx strobe counters
   typedef struct packed {
      logic          who_loc;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } op_t;
   op_t ops[$];
   int  consec    = 0;
   int  tx_pulses = 0;
   logic prev_en  = 1'b0;

   always @(negedge clk) begin
      if (ram_en) ops.push_back('{who_loc: loc_gnt, we: ram_we, addr: ram_addr, wdata: ram_wdata});
      if (ram_en && prev_en) consec++;
      if (spi_tx_valid) tx_pulses++;
      prev_en = ram_en;
   end

   typedef struct {
      logic [DW+1:0] rx;
      logic          exp_tx;
      logic [DW-1:0] exp_data;
   } vec_t;
   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_spi_tx_valid"}, spi_tx_valid, 0);
      check({pfx, "_spi_tx_data"},  spi_tx_data,  0);
      check({pfx, "_spi_ovf"},      spi_ovf,      0);
      check({pfx, "_loc_gnt"},      loc_gnt,      0);
      check({pfx, "_loc_rdata"},    loc_rdata,    0);
      check({pfx, "_loc_rvalid"},   loc_rvalid,   0);
      check({pfx, "_ram_en"},       ram_en,       0);
      check({pfx, "_ram_we"},       ram_we,       0);
      check({pfx, "_ram_addr"},     ram_addr,     0);
      check({pfx, "_ram_wdata"},    ram_wdata,    0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      spi_rx_valid = 1'b0;
      loc_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Caller is 1 ns after a rising edge; the word is sampled at the next edge
   task automatic send_rx(input logic [DW+1:0] w);
      spi_rx_valid = 1'b1;
      spi_rx_data  = w;
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      int            first;
      int            pulses;
      logic [DW-1:0] data;
      first  = 0;
      pulses = 0;
      data   = '0;
      send_rx(v.rx);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (spi_tx_valid) begin
            pulses++;
            if (first == 0) begin
               first = k;
               data  = spi_tx_data;
            end
         end
      end
      if (v.exp_tx) begin
         check({tag, "_tx_latency"}, first,  3);
         check({tag, "_tx_data"},    data,   v.exp_data);
         check({tag, "_tx_pulses"},  pulses, 1);
      end else begin
         check({tag, "_no_tx"}, pulses, 0);
      end
   endtask

   task automatic loc_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         output logic gnt_ok, output logic rd_ok, output logic [DW-1:0] rd);
      loc_req   = 1'b1;
      loc_we    = we;
      loc_addr  = addr;
      loc_wdata = wd;
      gnt_ok    = 1'b0;
      rd_ok     = 1'b0;
      rd        = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (loc_gnt) begin
            gnt_ok = 1'b1;
            break;
         end
      end
      loc_req = 1'b0;
      if (gnt_ok && !we) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (loc_rvalid) begin
               rd_ok = 1'b1;
               rd    = loc_rdata;
               break;
            end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=completion");
      $fatal(1);
   end

   initial begin
      int            base;
      int            pulses0;
      logic          g_ok;
      logic          r_ok;
      logic [DW-1:0] rd;
      vec_t          v;

      vecs[0]  = '{10'h2A5, 1'b0, 8'h00};
      vecs[1]  = '{10'h300, 1'b1, 8'h3C};
      vecs[2]  = '{10'h011, 1'b0, 8'h00};
      vecs[3]  = '{10'h1EE, 1'b0, 8'h00};
      vecs[4]  = '{10'h211, 1'b0, 8'h00};
      vecs[5]  = '{10'h3AB, 1'b1, 8'hEE};
      vecs[6]  = '{10'h0FF, 1'b0, 8'h00};
      vecs[7]  = '{10'h122, 1'b0, 8'h00};
      vecs[8]  = '{10'h2FF, 1'b0, 8'h00};
      vecs[9]  = '{10'h300, 1'b1, 8'h22};
      vecs[10] = '{10'h2A5, 1'b0, 8'h00};
      vecs[11] = '{10'h3FF, 1'b1, 8'h3C};

      rst = 1'b1;
      spi_rx_valid = 1'b0;
      spi_rx_data  = '0;
      loc_req = 1'b0;
      loc_we = 1'b0;
      loc_addr = '0;
      loc_wdata = '0;

      do_reset();
      check_outputs_zero("reset");

      // Test 1: set write address, write one byte
      base = ops.size();
      send_rx(10'h0A5);
      wait_cycles(4);
      send_rx(10'h13C);
      wait_cycles(6);
      check("t1_ram_en_count", ops.size() - base, 1);
      if (ops.size() > base) begin
         check("t1_we",    ops[base].we,    1);
         check("t1_addr",  ops[base].addr,  8'hA5);
         check("t1_wdata", ops[base].wdata, 8'h3C);
      end

      // Table: SPI read/write sequences with expected tx data and latency
      for (int i = 0; i < 12; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Test 3: SPI write pending while LOC write arrives; SPI wins the first tie
      do_reset();
      ops.delete();
      send_rx(10'h155);
      loc_op(1'b1, 8'h10, 8'h77, g_ok, r_ok, rd);
      wait_cycles(2);
      check("t3_loc_wr_gnt", g_ok, 1);
      check("t3_op_count", ops.size(), 2);
      if (ops.size() >= 2) begin
         check("t3_first_is_spi",  ops[0].who_loc, 0);
         check("t3_spi_addr",      ops[0].addr,    8'h00);
         check("t3_spi_wdata",     ops[0].wdata,   8'h55);
         check("t3_second_is_loc", ops[1].who_loc, 1);
         check("t3_loc_addr",      ops[1].addr,    8'h10);
         check("t3_loc_wdata",     ops[1].wdata,   8'h77);
      end
      loc_op(1'b0, 8'h10, 8'h00, g_ok, r_ok, rd);
      check("t3_loc_rd_gnt",    g_ok, 1);
      check("t3_loc_rd_rvalid", r_ok, 1);
      check("t3_loc_rdata",     rd,   8'h77);

      // Test 4: both sides requesting continuously -> strict alternation
      do_reset();
      ops.delete();
      send_rx(10'h101);
      loc_req = 1'b1;
      loc_we = 1'b1;
      loc_addr = 8'h20;
      loc_wdata = 8'h99;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         spi_rx_valid = 1'b0;
         if (ops.size() >= 8) break;
         if (ram_en && !loc_gnt) begin
            spi_rx_valid = 1'b1;
            spi_rx_data  = 10'h100 | 10'(i);
         end
      end
      loc_req = 1'b0;
      spi_rx_valid = 1'b0;
      wait_cycles(8);
      check("t4_grants_reached", ops.size() >= 8, 1);
      if (ops.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_grant%0d_side", i), ops[i].who_loc, i % 2);
         end
      end
      check("t4_no_ovf", spi_ovf, 0);

      // Test 5: two rx words while LOC read is in flight; the second is dropped
      do_reset();
      ops.delete();
      loc_req = 1'b1;
      loc_we = 1'b0;
      loc_addr = 8'h10;
      @(posedge clk); #1;
      check("t5_loc_gnt", loc_gnt, 1);
      check("t5_ovf_clear_before", spi_ovf, 0);
      loc_req = 1'b0;
      spi_rx_valid = 1'b1;
      spi_rx_data  = 10'h1C3;
      @(posedge clk); #1;
      spi_rx_data  = 10'h1DD;
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      check("t5_loc_rvalid", loc_rvalid, 1);
      check("t5_loc_rdata",  loc_rdata,  8'h77);
      check("t5_ovf_set",    spi_ovf,    1);
      wait_cycles(8);
      check("t5_op_count", ops.size(), 2);
      if (ops.size() >= 2) begin
         check("t5_spi_we",    ops[1].we,    1);
         check("t5_spi_wdata", ops[1].wdata, 8'hC3);
         check("t5_spi_addr",  ops[1].addr,  8'h00);
      end
      send_rx(10'h000);
      wait_cycles(4);
      check("t5_ovf_sticky", spi_ovf, 1);

      // Test 6: reset during RESP of an SPI read aborts the response
      send_rx(10'h300);
      @(posedge clk); #1;
      check("t6_access_ram_en", ram_en, 1);
      @(posedge clk); #1;
      pulses0 = tx_pulses;
      rst = 1'b1;
      #1;
      check_outputs_zero("t6_async");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_cycles(4);
      check("t6_no_tx_pulse", tx_pulses - pulses0, 0);
      v = '{10'h300, 1'b1, 8'hC3};
      apply_vec(v, "t6_reread");

      check("ram_en_never_consecutive", consec, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
